// File: rtl/cdb_arbiter.sv
// Result collector ahead of the CDB: per-FU FIFOs, round-robin pick, registered broadcast packet.
// Optional perf counters are enabled by defining CDB_PERF_CNT_EN.
module cdb_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int PREG_WIDTH = 6,
  parameter int ROB_DEPTH  = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic [NUM_FU-1:0]                      fu_valid,
  output logic [NUM_FU-1:0]                      fu_ready,
  input  logic [NUM_FU*PREG_WIDTH-1:0]           fu_pd,
  input  logic [NUM_FU*5-1:0]                    fu_rd,
  input  logic [NUM_FU*$clog2(ROB_DEPTH)-1:0]    fu_rob_idx,
  input  logic [NUM_FU*32-1:0]                   fu_data,
  input  logic [NUM_FU-1:0]                      fu_regf_we,
  input  logic [NUM_FU-1:0]                      fu_jump,
  input  logic [NUM_FU*32-1:0]                   fu_jump_pc,
  output logic                                   valid_to_broadcast,
  output logic                                   regf_we_reg,
  output logic                                   jump_reg,
  output logic [31:0]                            jump_pc_next_reg,
  output logic [PREG_WIDTH-1:0]                  pd_cdb,
  output logic [4:0]                             rd_cdb,
  output logic [$clog2(ROB_DEPTH)-1:0]           rob_idx_cdb,
  output logic [31:0]                            data_cdb,
  output logic [31:0]                            perf_bcast_cnt,
  output logic [31:0]                            perf_stall_cnt
);

  localparam int RW = $clog2(ROB_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic [PREG_WIDTH-1:0] pd;
    logic [4:0]            rd;
    logic [RW-1:0]         rob_idx;
    logic [31:0]           data;
    logic                  regf_we;
    logic                  jump;
    logic [31:0]           jump_pc;
  } entry_t;

  entry_t          mem_r    [NUM_FU][FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_r [NUM_FU];
  logic [PW-1:0]   rd_ptr_r [NUM_FU];
  logic [CW-1:0]   count_r  [NUM_FU];
  logic [FW-1:0]   rr_ptr_r;

  entry_t          in_entry_s [NUM_FU];
  logic [NUM_FU-1:0] push_s;
  logic [NUM_FU-1:0] pop_s;
  logic            win_valid_s;
  logic [FW-1:0]   win_idx_s;
  logic [FW-1:0]   next_rr_s;
  entry_t          head_s;

  // Slice the flat FU buses into per-unit entries and derive ready/push.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      in_entry_s[i].pd      = fu_pd[i*PREG_WIDTH +: PREG_WIDTH];
      in_entry_s[i].rd      = fu_rd[i*5 +: 5];
      in_entry_s[i].rob_idx = fu_rob_idx[i*RW +: RW];
      in_entry_s[i].data    = fu_data[i*32 +: 32];
      in_entry_s[i].regf_we = fu_regf_we[i];
      in_entry_s[i].jump    = fu_jump[i];
      in_entry_s[i].jump_pc = fu_jump_pc[i*32 +: 32];
      // No pop-through: readiness depends only on the registered count.
      fu_ready[i]           = (count_r[i] < CW'(FIFO_DEPTH));
      push_s[i]             = fu_valid[i] & fu_ready[i];
    end
  end

  // Round-robin scan from rr_ptr for the first non-empty FIFO.
  always_comb begin
    win_valid_s = 1'b0;
    win_idx_s   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      automatic int cand = (int'(rr_ptr_r) + k) % NUM_FU;
      if (!win_valid_s && (count_r[cand] != '0)) begin
        win_valid_s = 1'b1;
        win_idx_s   = FW'(cand);
      end else begin
        win_idx_s   = win_idx_s;
      end
    end
    if (int'(win_idx_s) == NUM_FU - 1) begin
      next_rr_s = '0;
    end else begin
      next_rr_s = win_idx_s + FW'(1);
    end
    for (int i = 0; i < NUM_FU; i++) begin
      pop_s[i] = win_valid_s && (int'(win_idx_s) == i);
    end
    head_s = mem_r[win_idx_s][rd_ptr_r[win_idx_s]];
  end

  // FIFO storage; contents need no reset because pointers and counts gate them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push_s[i]) begin
        mem_r[i][wr_ptr_r[i]] <= in_entry_s[i];
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (rst || flush) begin
        wr_ptr_r[i] <= '0;
        rd_ptr_r[i] <= '0;
        count_r[i]  <= '0;
      end else begin
        if (push_s[i]) begin
          wr_ptr_r[i] <= wr_ptr_r[i] + PW'(1);
        end
        if (pop_s[i]) begin
          rd_ptr_r[i] <= rd_ptr_r[i] + PW'(1);
        end
        case ({push_s[i], pop_s[i]})
          2'b10:   count_r[i] <= count_r[i] + CW'(1);
          2'b01:   count_r[i] <= count_r[i] - CW'(1);
          default: count_r[i] <= count_r[i];
        endcase
      end
    end
  end

  // Broadcast register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r           <= '0;
      valid_to_broadcast <= 1'b0;
      regf_we_reg        <= 1'b0;
      jump_reg           <= 1'b0;
      jump_pc_next_reg   <= 32'd0;
      pd_cdb             <= '0;
      rd_cdb             <= 5'd0;
      rob_idx_cdb        <= '0;
      data_cdb           <= 32'd0;
    end else if (flush) begin
      rr_ptr_r           <= '0;
      valid_to_broadcast <= 1'b0;
      regf_we_reg        <= 1'b0;
      jump_reg           <= 1'b0;
    end else if (win_valid_s) begin
      rr_ptr_r           <= next_rr_s;
      valid_to_broadcast <= 1'b1;
      regf_we_reg        <= head_s.regf_we;
      jump_reg           <= head_s.jump;
      jump_pc_next_reg   <= head_s.jump_pc;
      pd_cdb             <= head_s.pd;
      rd_cdb             <= head_s.rd;
      rob_idx_cdb        <= head_s.rob_idx;
      data_cdb           <= head_s.data;
    end else begin
      valid_to_broadcast <= 1'b0;
    end
  end

`ifdef CDB_PERF_CNT_EN
  logic [31:0] perf_bcast_r;
  logic [31:0] perf_stall_r;

  // Performance counters survive flush; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bcast_r <= 32'd0;
      perf_stall_r <= 32'd0;
    end else begin
      if (win_valid_s && !flush) begin
        perf_bcast_r <= perf_bcast_r + 32'd1;
      end
      if (|(fu_valid & ~fu_ready)) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
    end
  end

  assign perf_bcast_cnt = perf_bcast_r;
  assign perf_stall_cnt = perf_stall_r;
`else
  assign perf_bcast_cnt = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table for arbitration/flush plus
// hand-written single, jump, backpressure and counter sequences.
module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [3:0]   fu_valid;
  logic [3:0]   fu_ready;
  logic [23:0]  fu_pd;
  logic [19:0]  fu_rd;
  logic [15:0]  fu_rob_idx;
  logic [127:0] fu_data;
  logic [3:0]   fu_regf_we;
  logic [3:0]   fu_jump;
  logic [127:0] fu_jump_pc;
  logic         valid_to_broadcast;
  logic         regf_we_reg;
  logic         jump_reg;
  logic [31:0]  jump_pc_next_reg;
  logic [5:0]   pd_cdb;
  logic [4:0]   rd_cdb;
  logic [3:0]   rob_idx_cdb;
  logic [31:0]  data_cdb;
  logic [31:0]  perf_bcast_cnt;
  logic [31:0]  perf_stall_cnt;

  int checks = 0;
  int errors = 0;

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_pd(fu_pd), .fu_rd(fu_rd), .fu_rob_idx(fu_rob_idx), .fu_data(fu_data),
    .fu_regf_we(fu_regf_we), .fu_jump(fu_jump), .fu_jump_pc(fu_jump_pc),
    .valid_to_broadcast(valid_to_broadcast), .regf_we_reg(regf_we_reg),
    .jump_reg(jump_reg), .jump_pc_next_reg(jump_pc_next_reg),
    .pd_cdb(pd_cdb), .rd_cdb(rd_cdb), .rob_idx_cdb(rob_idx_cdb), .data_cdb(data_cdb),
    .perf_bcast_cnt(perf_bcast_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       flush;
    logic [3:0] valid;
    logic [7:0] tag;
    logic       exp_v;
    logic [1:0] exp_fu;
    logic [7:0] exp_tag;
    logic [3:0] exp_ready;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stimulus encoding used by the vector table.
  function automatic logic [31:0] t_data(logic [1:0] fu, logic [7:0] tag);
    return {16'hC0DE, tag, 6'd0, fu};
  endfunction
  function automatic logic [5:0] t_pd(logic [1:0] fu, logic [7:0] tag);
    return tag[5:0] ^ {4'd0, fu};
  endfunction
  function automatic logic [31:0] t_jpc(logic [1:0] fu, logic [7:0] tag);
    return {8'h10, tag, 14'd0, fu};
  endfunction

  task automatic set_fu(input int i, input logic [5:0] pd, input logic [4:0] rd,
                        input logic [3:0] rob, input logic [31:0] data,
                        input logic we, input logic jmp, input logic [31:0] jpc);
    fu_pd[i*6 +: 6]        = pd;
    fu_rd[i*5 +: 5]        = rd;
    fu_rob_idx[i*4 +: 4]   = rob;
    fu_data[i*32 +: 32]    = data;
    fu_regf_we[i]          = we;
    fu_jump[i]             = jmp;
    fu_jump_pc[i*32 +: 32] = jpc;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; fu_valid = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  logic [31:0] q[4][$];
  int          seq[4];
  int          nbcast;

  task automatic score();
    logic [7:0]  fu;
    logic [31:0] expd;
    if (valid_to_broadcast) begin
      nbcast++;
      fu = data_cdb[31:24];
      if (fu > 8'd3 || q[fu[1:0]].size() == 0) begin
        chk("bp_unexpected", data_cdb, 32'hFFFF_FFFF);
      end else begin
        expd = q[fu[1:0]].pop_front();
        chk("bp_order", data_cdb, expd);
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; fu_valid = 4'b0000;
    fu_pd = '0; fu_rd = '0; fu_rob_idx = '0; fu_data = '0;
    fu_regf_we = '0; fu_jump = '0; fu_jump_pc = '0;
    @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_valid", {31'd0, valid_to_broadcast}, 32'd0);
    chk("rst_regf_we", {31'd0, regf_we_reg}, 32'd0);
    chk("rst_jump", {31'd0, jump_reg}, 32'd0);
    chk("rst_jpc", jump_pc_next_reg, 32'd0);
    chk("rst_pd", {26'd0, pd_cdb}, 32'd0);
    chk("rst_rd", {27'd0, rd_cdb}, 32'd0);
    chk("rst_rob", {28'd0, rob_idx_cdb}, 32'd0);
    chk("rst_data", data_cdb, 32'd0);
    chk("rst_ready", {28'd0, fu_ready}, 32'hF);

    // Fairness, wrap, fill, flush and post-flush vectors
    vecs[0]  = '{1'b0, 4'b1111, 8'h20, 1'b0, 2'd0, 8'h00, 4'b1111};
    vecs[1]  = '{1'b0, 4'b0000, 8'h00, 1'b1, 2'd0, 8'h20, 4'b1111};
    vecs[2]  = '{1'b0, 4'b0000, 8'h00, 1'b1, 2'd1, 8'h20, 4'b1111};
    vecs[3]  = '{1'b0, 4'b0000, 8'h00, 1'b1, 2'd2, 8'h20, 4'b1111};
    vecs[4]  = '{1'b0, 4'b0000, 8'h00, 1'b1, 2'd3, 8'h20, 4'b1111};
    vecs[5]  = '{1'b0, 4'b1111, 8'h31, 1'b0, 2'd0, 8'h00, 4'b1111};
    vecs[6]  = '{1'b0, 4'b0000, 8'h00, 1'b1, 2'd0, 8'h31, 4'b1111};
    vecs[7]  = '{1'b0, 4'b0000, 8'h00, 1'b1, 2'd1, 8'h31, 4'b1111};
    vecs[8]  = '{1'b0, 4'b0000, 8'h00, 1'b1, 2'd2, 8'h31, 4'b1111};
    vecs[9]  = '{1'b0, 4'b0000, 8'h00, 1'b1, 2'd3, 8'h31, 4'b1111};
    vecs[10] = '{1'b0, 4'b1111, 8'h42, 1'b0, 2'd0, 8'h00, 4'b1111};
    vecs[11] = '{1'b0, 4'b1111, 8'h43, 1'b1, 2'd0, 8'h42, 4'b0001};
    vecs[12] = '{1'b0, 4'b1111, 8'h44, 1'b1, 2'd1, 8'h42, 4'b0010};
    vecs[13] = '{1'b1, 4'b1111, 8'h45, 1'b0, 2'd0, 8'h00, 4'b1111};
    vecs[14] = '{1'b0, 4'b0000, 8'h00, 1'b0, 2'd0, 8'h00, 4'b1111};
    vecs[15] = '{1'b0, 4'b0000, 8'h00, 1'b0, 2'd0, 8'h00, 4'b1111};
    vecs[16] = '{1'b0, 4'b0010, 8'h56, 1'b0, 2'd0, 8'h00, 4'b1111};
    vecs[17] = '{1'b0, 4'b0000, 8'h00, 1'b1, 2'd1, 8'h56, 4'b1111};
    vecs[18] = '{1'b0, 4'b0000, 8'h00, 1'b0, 2'd0, 8'h00, 4'b1111};

    for (int v = 0; v < 19; v++) begin
      flush    = vecs[v].flush;
      fu_valid = vecs[v].valid;
      for (int i = 0; i < 4; i++) begin
        set_fu(i, t_pd(2'(i), vecs[v].tag), {vecs[v].tag[2:0], 2'(i)}, vecs[v].tag[3:0],
               t_data(2'(i), vecs[v].tag), vecs[v].tag[0], vecs[v].tag[1], t_jpc(2'(i), vecs[v].tag));
      end
      tick();
      chk($sformatf("v%0d_valid", v), {31'd0, valid_to_broadcast}, {31'd0, vecs[v].exp_v});
      chk($sformatf("v%0d_ready", v), {28'd0, fu_ready}, {28'd0, vecs[v].exp_ready});
      if (vecs[v].exp_v) begin
        chk($sformatf("v%0d_data", v), data_cdb, t_data(vecs[v].exp_fu, vecs[v].exp_tag));
        chk($sformatf("v%0d_pd", v), {26'd0, pd_cdb}, {26'd0, t_pd(vecs[v].exp_fu, vecs[v].exp_tag)});
        chk($sformatf("v%0d_rd", v), {27'd0, rd_cdb}, {27'd0, vecs[v].exp_tag[2:0], vecs[v].exp_fu});
        chk($sformatf("v%0d_rob", v), {28'd0, rob_idx_cdb}, {28'd0, vecs[v].exp_tag[3:0]});
        chk($sformatf("v%0d_we", v), {31'd0, regf_we_reg}, {31'd0, vecs[v].exp_tag[0]});
        chk($sformatf("v%0d_jump", v), {31'd0, jump_reg}, {31'd0, vecs[v].exp_tag[1]});
        chk($sformatf("v%0d_jpc", v), jump_pc_next_reg, t_jpc(vecs[v].exp_fu, vecs[v].exp_tag));
      end
    end
    flush = 1'b0; fu_valid = 4'b0000;

    // Single result from FU2: visible two edges after presentation, for one cycle
    do_reset();
    fu_valid = 4'b0100;
    set_fu(2, 6'd5, 5'd7, 4'd3, 32'hDEADBEEF, 1'b1, 1'b0, 32'd0);
    tick();
    fu_valid = 4'b0000;
    chk("single_early", {31'd0, valid_to_broadcast}, 32'd0);
    tick();
    chk("single_valid", {31'd0, valid_to_broadcast}, 32'd1);
    chk("single_pd", {26'd0, pd_cdb}, 32'd5);
    chk("single_rd", {27'd0, rd_cdb}, 32'd7);
    chk("single_rob", {28'd0, rob_idx_cdb}, 32'd3);
    chk("single_data", data_cdb, 32'hDEADBEEF);
    chk("single_we", {31'd0, regf_we_reg}, 32'd1);
    chk("single_jump", {31'd0, jump_reg}, 32'd0);
    tick();
    chk("single_once", {31'd0, valid_to_broadcast}, 32'd0);
    tick();
    chk("single_quiet", {31'd0, valid_to_broadcast}, 32'd0);

    // Jump packet from FU3 with link write
    fu_valid = 4'b1000;
    set_fu(3, 6'd9, 5'd1, 4'd7, 32'h12345678, 1'b1, 1'b1, 32'h1000_0040);
    tick();
    fu_valid = 4'b0000;
    tick();
    chk("jump_valid", {31'd0, valid_to_broadcast}, 32'd1);
    chk("jump_reg", {31'd0, jump_reg}, 32'd1);
    chk("jump_pc", jump_pc_next_reg, 32'h1000_0040);
    chk("jump_we", {31'd0, regf_we_reg}, 32'd1);
    chk("jump_data", data_cdb, 32'h12345678);
    chk("jump_rob", {28'd0, rob_idx_cdb}, 32'd7);

    // Backpressure: every FU offers results for 6 cycles, holding until accepted
    do_reset();
    for (int i = 0; i < 4; i++) begin
      seq[i] = 0;
      set_fu(i, 6'd0, 5'd0, 4'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    end
    nbcast = 0;
    for (int c = 0; c < 6; c++) begin
      score();
      fu_valid = 4'b1111;
      if (c == 3) begin
        chk("bp_ready0_low", {31'd0, fu_ready[0]}, 32'd0);
      end
      for (int i = 0; i < 4; i++) begin
        fu_data[i*32 +: 32] = {8'(i), 8'hBB, 16'(seq[i])};
        if (fu_ready[i]) begin
          q[i].push_back({8'(i), 8'hBB, 16'(seq[i])});
          seq[i]++;
        end
      end
      tick();
    end
    fu_valid = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      score();
      tick();
    end
    chk("bp_fu0_accepts", 32'(seq[0]), 32'd3);
    chk("bp_total_bcast", 32'(nbcast), 32'd12);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_drained%0d", i), 32'(q[i].size()), 32'd0);
    end

    // Counter scenario: 10 broadcasts, 3 stall cycles, then a flush
    do_reset();
    fu_valid = 4'b1111; tick();
    fu_valid = 4'b1111; tick();
    fu_valid = 4'b1110; tick();
    fu_valid = 4'b1110; tick();
    fu_valid = 4'b1110; tick();
    fu_valid = 4'b0000;
    for (int c = 0; c < 15; c++) tick();
`ifdef CDB_PERF_CNT_EN
    chk("perf_bcast", perf_bcast_cnt, 32'd10);
    chk("perf_stall", perf_stall_cnt, 32'd3);
`else
    chk("perf_bcast_off", perf_bcast_cnt, 32'd0);
    chk("perf_stall_off", perf_stall_cnt, 32'd0);
`endif
    flush = 1'b1; tick();
    flush = 1'b0; tick();
`ifdef CDB_PERF_CNT_EN
    chk("perf_bcast_flush", perf_bcast_cnt, 32'd10);
    chk("perf_stall_flush", perf_stall_cnt, 32'd3);
`else
    chk("perf_bcast_off_flush", perf_bcast_cnt, 32'd0);
    chk("perf_stall_off_flush", perf_stall_cnt, 32'd0);
`endif
    chk("final_ready", {28'd0, fu_ready}, 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
